// File: rtl/io_expander_pkg.sv
// Shared constants and types for the I2C GPIO expander scheduler.
//   - Expander register indices and the configuration values written after reset.
//   - Scheduler FSM state encoding.
//   - Kind tag for the transaction in flight, used to route its completion.
package io_expander_pkg;

   // Expander register map
   localparam logic [7:0] REG_IN1  = 8'h01;  // port 1 input byte (buttons)
   localparam logic [7:0] REG_OUT0 = 8'h02;  // port 0 output byte {link_pow, led}
   localparam logic [7:0] REG_CFG0 = 8'h06;  // port 0 direction
   localparam logic [7:0] REG_CFG1 = 8'h07;  // port 1 direction

   // Direction values: 0 = output, 1 = input
   localparam logic [7:0] CFG0_VAL = 8'h00;
   localparam logic [7:0] CFG1_VAL = 8'hFF;

   typedef enum logic [2:0] {
      StInit0   = 3'd0,
      StInit1   = 3'd1,
      StIdle    = 3'd2,
      StIssue   = 3'd3,
      StWait    = 3'd4,
      StBackoff = 3'd5
   } state_e;

   typedef enum logic [1:0] {
      KindCfg0  = 2'd0,
      KindCfg1  = 2'd1,
      KindWrite = 2'd2,
      KindRead  = 2'd3
   } txn_kind_e;

endpackage

// File: rtl/io_expander_timer.sv
// Periodic cycle timer with a single-cycle wrap pulse.
//   i_clk    : clock
//   i_reset  : asynchronous active-high reset, count returns to zero
//   i_en     : advance the count this cycle
//   i_clear  : synchronously return the count to zero (wins over i_en)
//   o_wrap   : high on the enabled cycle that completes a CYCLES-long period
// With i_en held high the pulse fires every CYCLES cycles, first on the CYCLES-th
// enabled cycle after reset or clear.
module io_expander_timer #(
   parameter int unsigned CYCLES = 100
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_en,
   input  logic i_clear,
   output logic o_wrap
);

   localparam int unsigned CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      o_wrap = i_en && (cnt_q == LAST_CNT);
      cnt_d  = cnt_q;
      if (i_clear) begin
         cnt_d = '0;
      end else if (i_en) begin
         cnt_d = o_wrap ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/io_expander_sched.sv
// Scheduler for all traffic to the I2C GPIO expander through one transaction-level
// I2C master. Configures port directions after reset, then arbitrates between
// output-register writes (LEDs, link power) and periodic button polls.
// Ports:
//   i_clk, i_reset        : clock, asynchronous active-high reset
//   i_led, i_link_pow     : requested output state; mirrored to the expander
//   o_button              : last successfully read button byte
//   o_nack_cnt            : saturating count of NACKed transactions
//   o_init_done           : both direction writes have been ACKed
//   o_txn_*               : request to the master, held stable while valid && !ready
//   i_txn_ready           : master accepts the request when valid && ready
//   i_txn_done/nack/rdata : completion pulse, failure flag and read data
module io_expander_sched
   import io_expander_pkg::*;
#(
   parameter int unsigned CLK_RATE_HZ  = 50_000_000,
   parameter int unsigned POLL_RATE_HZ = 100,
   parameter int unsigned RETRY_CYCLES = 5000,
   parameter logic [6:0]  DEV_ADDR     = 7'h20
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [3:0] i_led,
   input  logic [3:0] i_link_pow,
   output logic [7:0] o_button,
   output logic [7:0] o_nack_cnt,
   output logic       o_init_done,
   output logic       o_txn_valid,
   input  logic       i_txn_ready,
   output logic [6:0] o_txn_addr,
   output logic       o_txn_rw,
   output logic [7:0] o_txn_reg,
   output logic [7:0] o_txn_wdata,
   input  logic       i_txn_done,
   input  logic       i_txn_nack,
   input  logic [7:0] i_txn_rdata
);

   localparam int unsigned POLL_CYCLES = CLK_RATE_HZ / POLL_RATE_HZ;

   state_e      state_q, state_d;
   txn_kind_e   kind_q, kind_d;
   logic [7:0]  shadow_q, shadow_d;
   logic [7:0]  button_q, button_d;
   logic [7:0]  nack_cnt_q, nack_cnt_d;
   logic        init_done_q, init_done_d;
   logic        valid_q, valid_d;
   logic        rw_q, rw_d;
   logic [7:0]  reg_q, reg_d;
   logic [7:0]  wdata_q, wdata_d;
   logic        poll_pend_q, poll_pend_d;

   logic [7:0]  want;
   logic        poll_wrap;
   logic        poll_clr;
   logic        backoff_active;
   logic        backoff_wrap;

   assign want           = {i_link_pow, i_led};
   assign backoff_active = (state_q == StBackoff);

   // Poll period runs only once the expander is configured.
   io_expander_timer #(
      .CYCLES (POLL_CYCLES)
   ) u_poll_timer (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_en    (init_done_q),
      .i_clear (1'b0),
      .o_wrap  (poll_wrap)
   );

   // Held at zero outside BACKOFF so every backoff lasts exactly RETRY_CYCLES.
   io_expander_timer #(
      .CYCLES (RETRY_CYCLES)
   ) u_backoff_timer (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_en    (backoff_active),
      .i_clear (!backoff_active),
      .o_wrap  (backoff_wrap)
   );

   always_comb begin
      state_d     = state_q;
      kind_d      = kind_q;
      shadow_d    = shadow_q;
      button_d    = button_q;
      nack_cnt_d  = nack_cnt_q;
      init_done_d = init_done_q;
      valid_d     = valid_q;
      rw_d        = rw_q;
      reg_d       = reg_q;
      wdata_d     = wdata_q;
      poll_clr    = 1'b0;

      unique case (state_q)
         StInit0: begin
            kind_d  = KindCfg0;
            reg_d   = REG_CFG0;
            wdata_d = CFG0_VAL;
            rw_d    = 1'b0;
            valid_d = 1'b1;
            state_d = StIssue;
         end

         StInit1: begin
            kind_d  = KindCfg1;
            reg_d   = REG_CFG1;
            wdata_d = CFG1_VAL;
            rw_d    = 1'b0;
            valid_d = 1'b1;
            state_d = StIssue;
         end

         StIdle: begin
            // Writes outrank polls; the snapshot taken here is what goes on the bus.
            if (want != shadow_q) begin
               kind_d  = KindWrite;
               reg_d   = REG_OUT0;
               wdata_d = want;
               rw_d    = 1'b0;
               valid_d = 1'b1;
               state_d = StIssue;
            end else if (poll_pend_q) begin
               kind_d   = KindRead;
               reg_d    = REG_IN1;
               rw_d     = 1'b1;
               valid_d  = 1'b1;
               poll_clr = 1'b1;
               state_d  = StIssue;
            end
         end

         StIssue: begin
            if (i_txn_ready) begin
               valid_d = 1'b0;
               state_d = StWait;
            end
         end

         StWait: begin
            if (i_txn_done) begin
               if (i_txn_nack) begin
                  if (nack_cnt_q != 8'hFF) begin
                     nack_cnt_d = nack_cnt_q + 8'd1;
                  end
                  state_d = StBackoff;
               end else begin
                  unique case (kind_q)
                     KindCfg0: begin
                        state_d = StInit1;
                     end
                     KindCfg1: begin
                        init_done_d = 1'b1;
                        state_d     = StIdle;
                     end
                     KindWrite: begin
                        shadow_d = wdata_q;
                        state_d  = StIdle;
                     end
                     KindRead: begin
                        button_d = i_txn_rdata;
                        state_d  = StIdle;
                     end
                     default: state_d = StIdle;
                  endcase
               end
            end
         end

         StBackoff: begin
            // A failed write re-arbitrates from IDLE and retries since the mismatch
            // persists; a failed poll is simply dropped.
            if (backoff_wrap) begin
               unique case (kind_q)
                  KindCfg0: state_d = StInit0;
                  KindCfg1: state_d = StInit1;
                  default:  state_d = StIdle;
               endcase
            end
         end

         default: state_d = StInit0;
      endcase
   end

   // A wrap coinciding with the IDLE clear keeps the request pending.
   assign poll_pend_d = poll_wrap | (poll_pend_q & ~poll_clr);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q     <= StInit0;
         kind_q      <= KindCfg0;
         shadow_q    <= 8'h00;
         button_q    <= 8'h00;
         nack_cnt_q  <= 8'h00;
         init_done_q <= 1'b0;
         valid_q     <= 1'b0;
         rw_q        <= 1'b0;
         reg_q       <= 8'h00;
         wdata_q     <= 8'h00;
         poll_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         kind_q      <= kind_d;
         shadow_q    <= shadow_d;
         button_q    <= button_d;
         nack_cnt_q  <= nack_cnt_d;
         init_done_q <= init_done_d;
         valid_q     <= valid_d;
         rw_q        <= rw_d;
         reg_q       <= reg_d;
         wdata_q     <= wdata_d;
         poll_pend_q <= poll_pend_d;
      end
   end

   assign o_button    = button_q;
   assign o_nack_cnt  = nack_cnt_q;
   assign o_init_done = init_done_q;
   assign o_txn_valid = valid_q;
   assign o_txn_addr  = DEV_ADDR;
   assign o_txn_rw    = rw_q;
   assign o_txn_reg   = reg_q;
   assign o_txn_wdata = wdata_q;

endmodule
